seq_arith_unit: RTL and testbench

//   Parametrised multi-cycle integer arithmetic unit. Supports ADD, SUB, MUL (iterative shift-add) and DIV (restoring).

---
 rtl/seq_arith_pkg.sv | 30 +++
 rtl/seq_arith_unit_addsub_core.sv | 30 +++
 rtl/seq_arith_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_seq_arith_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// ============================================================================
// seq_arith_pkg : shared opcode/state types and iteration-count helper
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic int unsigned iters(input op_e o, input int unsigned width);
    if (o == OP_MUL || o == OP_DIV) return width;
    return 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_arith_unit_addsub_core.sv
// ============================================================================
// addsub_core : WIDTH-bit adder/subtractor with carry-out and signed overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module addsub_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sovf
);

  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff       = sub ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    // Overflow when both addends share a sign the sum does not.
    sovf        = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

`default_nettype wire

// File: rtl/seq_arith_unit.sv
// ============================================================================
// seq_arith_unit : multi-cycle ADD/SUB/MUL/DIV unit with valid/ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             ovf,
  output logic             neg,
  output logic             zero,
  output logic             div0
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             sgn_q, sgn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opx_q, opx_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             minneg_q, minneg_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0]   add_a, add_sum;
  logic               add_sub, add_cout, add_sovf;
  logic [WIDTH-1:0]   a_mag, b_mag, fix_lo, fix_hi;
  logic [2*WIDTH-1:0] prod;
  logic               div_ok, fix_ovf;

  // Adder operand A depends on the op: raw A, MUL high accumulator, or DIV shifted remainder.
  always_comb begin
    add_sub = (op_q == OP_SUB) || (op_q == OP_DIV);
    case (op_q)
      OP_MUL:  add_a = hi_q;
      OP_DIV:  add_a = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      default: add_a = lo_q;
    endcase
  end

  addsub_core #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (opx_q),
    .sub  (add_sub),
    .cin  (add_sub),
    .sum  (add_sum),
    .cout (add_cout),
    .sovf (add_sovf)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    opx_d     = opx_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    araw_d    = araw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    minneg_d  = minneg_q;
    cy_d      = cy_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    div0_d    = div0_q;
    a_mag     = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag     = (sgn && b[WIDTH-1]) ? -b : b;
    div_ok    = hi_q[WIDTH-1] | add_cout;
    prod      = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    fix_lo    = lo_q;
    fix_hi    = '0;
    fix_ovf   = cy_q;

    case (op_q)
      OP_MUL: begin
        fix_lo  = prod[WIDTH-1:0];
        fix_hi  = prod[2*WIDTH-1:WIDTH];
        fix_ovf = sgn_q ? (fix_hi != {WIDTH{fix_lo[WIDTH-1]}}) : (fix_hi != '0);
      end
      OP_DIV: begin
        fix_ovf = 1'b0;
        if (dz_q) begin
          fix_lo = '1;
          fix_hi = araw_q;
        end else if (minneg_q) begin
          fix_lo  = {1'b1, {(WIDTH-1){1'b0}}};
          fix_ovf = 1'b1;
        end else begin
          fix_lo = neg_res_q ? -lo_q : lo_q;
          fix_hi = neg_rem_q ? -hi_q : hi_q;
        end
      end
      default: ;
    endcase

    if (clr) begin
      state_d  = S_IDLE;
      res_lo_d = '0;
      res_hi_d = '0;
      ovf_d    = 1'b0;
      neg_d    = 1'b0;
      zero_d   = 1'b0;
      div0_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d      = op_e'(op);
            sgn_d     = sgn;
            cnt_d     = CNT_W'(iters(op_e'(op), WIDTH) - 1);
            araw_d    = a;
            hi_d      = '0;
            neg_res_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = sgn & a[WIDTH-1];
            dz_d      = (b == '0);
            minneg_d  = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
            case (op_e'(op))
              OP_MUL:  begin lo_d = b_mag; opx_d = a_mag; end
              OP_DIV:  begin lo_d = a_mag; opx_d = b_mag; end
              default: begin lo_d = a;     opx_d = b;     end
            endcase
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          case (op_q)
            OP_MUL: {hi_d, lo_d} = {lo_q[0] & add_cout, lo_q[0] ? add_sum : hi_q,
                                    lo_q[WIDTH-1:1]};
            OP_DIV: begin
              hi_d = div_ok ? add_sum : add_a;
              lo_d = {lo_q[WIDTH-2:0], div_ok};
            end
            default: begin
              lo_d = add_sum;
              cy_d = sgn_q ? add_sovf : ((op_q == OP_ADD) ? add_cout : ~add_cout);
            end
          endcase
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          res_lo_d = fix_lo;
          res_hi_d = fix_hi;
          ovf_d    = fix_ovf;
          neg_d    = sgn_q & ((op_q == OP_MUL) ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1]);
          zero_d   = (op_q == OP_MUL) ? ({fix_hi, fix_lo} == '0) : (fix_lo == '0);
          div0_d   = (op_q == OP_DIV) && dz_q;
          state_d  = S_DONE;
        end
        default: begin
          if (rsp_ready) begin
            state_d  = S_IDLE;
            res_lo_d = '0;
            res_hi_d = '0;
            ovf_d    = 1'b0;
            neg_d    = 1'b0;
            zero_d   = 1'b0;
            div0_d   = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      sgn_q     <= 1'b0;
      cnt_q     <= '0;
      opx_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      araw_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      minneg_q  <= 1'b0;
      cy_q      <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sgn_q     <= sgn_d;
      cnt_q     <= cnt_d;
      opx_q     <= opx_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      araw_q    <= araw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      minneg_q  <= minneg_d;
      cy_q      <= cy_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      div0_q    <= div0_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign res_lo    = res_lo_q;
  assign res_hi    = res_hi_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign div0      = div0_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
// ============================================================================
// tb_seq_arith_unit : directed self-checking bench for seq_arith_unit (WIDTH=16)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_arith_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  op = 2'b00;
  logic        sgn = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] res_lo, res_hi;
  logic        ovf, neg, zero, div0;

  int n_tests = 0;
  int n_fail  = 0;

  seq_arith_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .sgn(sgn), .a(a), .b(b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .res_lo(res_lo), .res_hi(res_hi), .ovf(ovf), .neg(neg), .zero(zero), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for the response, capture it, then complete the handshake.
  task automatic run_op(input logic [1:0] o, input logic s, input logic [15:0] x,
                        input logic [15:0] y, output logic [15:0] lo, output logic [15:0] hi,
                        output logic [3:0] fl, output int lat);
    @(negedge clk);
    check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
    op = o; sgn = s; a = x; b = y; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    lo = '0; hi = '0; fl = '0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check_eq("rsp_timeout", 32'd0, 32'd1);
    lo = res_lo; hi = res_hi; fl = {ovf, neg, zero, div0};
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check_eq("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("post_hs_flags", {27'b0, res_lo == 16'h0, ovf, neg, zero, div0}, 32'h10);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  o;
    logic        s;
    logic [15:0] x, y, lo, hi;
    logic [3:0]  fl;  // {ovf, neg, zero, div0}
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] lo, hi;
    logic [3:0]  fl;
    int          lat;
    int          seen;

    vecs.push_back('{"add_sovf",   2'b00, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1100, 2});
    vecs.push_back('{"add_carry",  2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 2});
    vecs.push_back('{"sub_borrow", 2'b01, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b1000, 2});
    vecs.push_back('{"sub_zero",   2'b01, 1'b1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0010, 2});
    vecs.push_back('{"mul_sneg",   2'b10, 1'b1, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 4'b0100, 17});
    vecs.push_back('{"mul_uovf",   2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1000, 17});
    vecs.push_back('{"mul_minmin", 2'b10, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 4'b1000, 17});
    vecs.push_back('{"mul_zero",   2'b10, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0010, 17});
    vecs.push_back('{"div_sneg",   2'b11, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 4'b0100, 17});
    vecs.push_back('{"div_sdiv",   2'b11, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 4'b0100, 17});
    vecs.push_back('{"div_udiv",   2'b11, 1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 4'b0000, 17});
    vecs.push_back('{"div_by0",    2'b11, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b0001, 17});
    vecs.push_back('{"div_minm1",  2'b11, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 4'b1100, 17});

    // Reset state
    #12;
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_res", {res_hi, res_lo}, 32'd0);
    check_eq("rst_flags", {28'b0, ovf, neg, zero, div0}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].o, vecs[i].s, vecs[i].x, vecs[i].y, lo, hi, fl, lat);
      check_eq({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check_eq({vecs[i].name, "_res"}, {hi, lo}, {vecs[i].hi, vecs[i].lo});
      check_eq({vecs[i].name, "_flags"}, {28'b0, fl}, {28'b0, vecs[i].fl});
    end

    // Backpressure: hold rsp_ready low while a second request waits.
    @(negedge clk);
    op = 2'b10; sgn = 1'b0; a = 16'd3; b = 16'd4; req_valid = 1'b1;
    @(posedge clk);
    #1 op = 2'b00; a = 16'd1; b = 16'd2;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); lat++; #1;
    end
    check_eq("bp_latency", lat, 17);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("bp_hold_ready", {31'b0, req_ready}, 32'd0);
      check_eq("bp_hold_res", {res_hi, res_lo}, 32'h0000000C);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check_eq("bp_release_idle", {30'b0, req_ready, rsp_valid}, 32'b10);
    @(posedge clk); #1 req_valid = 1'b0;
    check_eq("bp_accept", {31'b0, req_ready}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("bp_second_valid", {31'b0, rsp_valid}, 32'd1);
    check_eq("bp_second_res", {res_hi, res_lo}, 32'h00000003);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Asynchronous reset in RUN cycle 8 of a MUL.
    @(negedge clk);
    op = 2'b10; sgn = 1'b0; a = 16'h0102; b = 16'h0304; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_now", {29'b0, rsp_valid, req_ready, res_lo == 16'h0}, 32'b011);
    check_eq("arst_res", {res_hi, res_lo}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check_eq("arst_no_result", seen, 0);

    // Synchronous clear in RUN cycle 8 of a MUL.
    @(negedge clk);
    op = 2'b10; sgn = 1'b0; a = 16'h0102; b = 16'h0304; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 clr = 1'b1;
    #1;
    check_eq("clr_before_edge", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1 clr = 1'b0;
    check_eq("clr_after_edge", {30'b0, rsp_valid, req_ready}, 32'b01);
    check_eq("clr_res", {res_hi, res_lo}, 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check_eq("clr_no_result", seen, 0);

    // Unit keeps working after the abort.
    run_op(2'b00, 1'b0, 16'h1111, 16'h2222, lo, hi, fl, lat);
    check_eq("after_clr_res", {hi, lo}, 32'h00003333);
    check_eq("after_clr_lat", lat, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
